// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST fault-campaign controller.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_EVAL,
        ST_FIN
    } state_e;

    function automatic int fault_idx_w(input int num_faults);
        return (num_faults > 1) ? $clog2(num_faults) : 1;
    endfunction

    // Index width for the default 16-entry fault list.
    localparam int FAULT_IDX_W = fault_idx_w(16);

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int bits);
        logic [31:0] max_val;
        max_val = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/fault_campaign_ctrl_if.sv
// Campaign-control bus: requests and TPG/ORA verdicts in, strobes and tallies out.
interface fault_campaign_ctrl_if #(
    parameter int IDX_W    = bist_pkg::FAULT_IDX_W,
    parameter int ERR_BITS = 16
);
    logic                i_start;
    logic                i_abort;
    logic                i_tpg_end;
    logic                i_ora_res;
    logic                o_tpg_clr;
    logic                o_tpg_en;
    logic                o_ora_clr;
    logic                o_fil_inc;
    logic                o_fil_clr;
    logic [IDX_W-1:0]    o_fault_idx;
    logic [ERR_BITS-1:0] o_det_count;
    logic [ERR_BITS-1:0] o_undet_count;
    logic                o_busy;
    logic                o_done;
    logic                o_golden_fail;

    modport slave (
        input  i_start, i_abort, i_tpg_end, i_ora_res,
        output o_tpg_clr, o_tpg_en, o_ora_clr, o_fil_inc, o_fil_clr,
               o_fault_idx, o_det_count, o_undet_count, o_busy, o_done, o_golden_fail
    );

    modport master (
        output i_start, i_abort, i_tpg_end, i_ora_res,
        input  o_tpg_clr, o_tpg_en, o_ora_clr, o_fil_inc, o_fil_clr,
               o_fault_idx, o_det_count, o_undet_count, o_busy, o_done, o_golden_fail
    );
endinterface

// File: rtl/lat_drain_cnt.sv
// Down-counter covering the ORA pipeline latency after the last TPG pattern.
module lat_drain_cnt #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last
);
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    // NOTE: async active-low reset in the sensitivity list; state uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LAT);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // High in the final drain cycle, i.e. the decrement that reaches zero.
    assign o_last = (r_cnt <= CNT_W'(1));
endmodule

// File: rtl/fault_campaign_ctrl.sv
// Sequences a golden run plus one run per injected fault and tallies ORA verdicts.
module fault_campaign_ctrl
    import bist_pkg::*;
#(
    parameter int IN_BITS    = 4,
    parameter int NUM_FAULTS = 16,
    parameter int ERR_BITS   = 16,
    parameter int ORA_LAT    = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fault_campaign_ctrl_if.slave  bus
);
    localparam int               IDX_W    = fault_idx_w(NUM_FAULTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FAULTS - 1);
    localparam logic [IN_BITS:0] PAT_MAX  = (IN_BITS + 1)'(2 ** IN_BITS);

    state_e              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [ERR_BITS-1:0] r_det, w_det_nxt;
    logic [ERR_BITS-1:0] r_undet, w_undet_nxt;
    logic                r_hit, w_hit_nxt;
    logic                r_done, w_done_nxt;
    logic                r_golden_fail, w_golden_fail_nxt;
    logic                w_fil_inc, w_fil_clr;
    logic                r_fil_inc, r_fil_clr;
    logic                r_tpg_clr, r_ora_clr, r_tpg_en, r_busy;
    logic                w_drain_load, w_drain_dec, w_drain_last;
    logic [IN_BITS:0]    r_pat_cnt;

    lat_drain_cnt #(.LAT(ORA_LAT)) u_drain (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_drain_load),
        .i_dec  (w_drain_dec),
        .o_last (w_drain_last)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_det_nxt         = r_det;
        w_undet_nxt       = r_undet;
        w_hit_nxt         = r_hit;
        w_done_nxt        = r_done;
        w_golden_fail_nxt = r_golden_fail;
        w_fil_inc         = 1'b0;
        w_fil_clr         = 1'b0;
        w_drain_load      = 1'b0;
        w_drain_dec       = 1'b0;

        if (bus.i_abort) begin
            w_state_nxt = ST_IDLE;
            w_fil_clr   = 1'b1;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (bus.i_start) begin
                        w_state_nxt       = ST_CLR;
                        w_idx_nxt         = '0;
                        w_det_nxt         = '0;
                        w_undet_nxt       = '0;
                        w_done_nxt        = 1'b0;
                        w_golden_fail_nxt = 1'b0;
                        w_fil_clr         = 1'b1;
                    end
                end
                ST_CLR: begin
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    w_hit_nxt = r_hit | bus.i_ora_res;
                    if ((EARLY_EXIT != 0) && bus.i_ora_res) begin
                        w_state_nxt = ST_EVAL;
                    end else if (bus.i_tpg_end) begin
                        if (ORA_LAT == 0) begin
                            w_state_nxt = ST_EVAL;
                        end else begin
                            w_state_nxt  = ST_DRAIN;
                            w_drain_load = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    w_hit_nxt   = r_hit | bus.i_ora_res;
                    w_drain_dec = 1'b1;
                    if (w_drain_last) begin
                        w_state_nxt = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // A mismatch on the fault-free run invalidates the whole campaign.
                    if ((r_idx == '0) && r_hit) begin
                        w_golden_fail_nxt = 1'b1;
                        w_done_nxt        = 1'b1;
                        w_state_nxt       = ST_FIN;
                    end else begin
                        if (r_idx != '0) begin
                            if (r_hit) begin
                                w_det_nxt = ERR_BITS'(sat_inc(32'(r_det), ERR_BITS));
                            end else begin
                                w_undet_nxt = ERR_BITS'(sat_inc(32'(r_undet), ERR_BITS));
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_fil_inc   = 1'b1;
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = ST_CLR;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_det         <= '0;
            r_undet       <= '0;
            r_hit         <= 1'b0;
            r_done        <= 1'b0;
            r_golden_fail <= 1'b0;
            r_fil_inc     <= 1'b0;
            r_fil_clr     <= 1'b0;
            r_tpg_clr     <= 1'b0;
            r_ora_clr     <= 1'b0;
            r_tpg_en      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_det         <= w_det_nxt;
            r_undet       <= w_undet_nxt;
            r_hit         <= w_hit_nxt;
            r_done        <= w_done_nxt;
            r_golden_fail <= w_golden_fail_nxt;
            r_fil_inc     <= w_fil_inc;
            r_fil_clr     <= w_fil_clr;
            r_tpg_clr     <= (w_state_nxt == ST_CLR);
            r_ora_clr     <= (w_state_nxt == ST_CLR);
            r_tpg_en      <= (w_state_nxt == ST_RUN);
            r_busy        <= (w_state_nxt inside {ST_CLR, ST_RUN, ST_DRAIN, ST_EVAL});
        end
    end

    // Length of the current RUN phase; a TPG never needs more than 2**IN_BITS patterns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_pat_cnt <= r_pat_cnt + (IN_BITS + 1)'(1);
        end else begin
            r_pat_cnt <= '0;
        end
    end

    a_tpg_bounded : assert property (@(posedge clk) disable iff (!rst) r_pat_cnt <= PAT_MAX);

    assign bus.o_tpg_clr     = r_tpg_clr;
    assign bus.o_tpg_en      = r_tpg_en;
    assign bus.o_ora_clr     = r_ora_clr;
    assign bus.o_fil_inc     = r_fil_inc;
    assign bus.o_fil_clr     = r_fil_clr;
    assign bus.o_fault_idx   = r_idx;
    assign bus.o_det_count   = r_det;
    assign bus.o_undet_count = r_undet;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_golden_fail = r_golden_fail;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench: three controller configurations driven by a small TPG/ORA stand-in.
module tb_fault_campaign_ctrl;
    import bist_pkg::*;

    localparam int PAT    = 4;
    localparam int BUDGET = 200;

    typedef struct packed {
        logic        tpg_clr;
        logic        tpg_en;
        logic        ora_clr;
        logic        fil_inc;
        logic        fil_clr;
        logic        busy;
        logic        done;
        logic        golden_fail;
        logic [7:0]  idx;
        logic [15:0] det;
        logic [15:0] undet;
    } obs_t;

    logic clk;
    logic rst;
    logic start, abort, tpg_end, ora_res;
    logic [1:0] sel;
    obs_t obs_a, obs_b, obs_c, obs;

    int n_checks = 0;
    int n_fail   = 0;

    int mis_run   [8];
    int mis_drain [8];
    int exp_gap   [8];
    int res_gap   [8];
    int res_fil_inc;
    int res_end_fil_clr;
    int res_ended;

    fault_campaign_ctrl_if #(.IDX_W(fault_idx_w(4)), .ERR_BITS(16)) if_a ();
    fault_campaign_ctrl_if #(.IDX_W(fault_idx_w(4)), .ERR_BITS(16)) if_b ();
    fault_campaign_ctrl_if #(.IDX_W(fault_idx_w(6)), .ERR_BITS(2))  if_c ();

    fault_campaign_ctrl #(.IN_BITS(2), .NUM_FAULTS(4), .ERR_BITS(16), .ORA_LAT(2), .EARLY_EXIT(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    fault_campaign_ctrl #(.IN_BITS(2), .NUM_FAULTS(4), .ERR_BITS(16), .ORA_LAT(2), .EARLY_EXIT(0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    fault_campaign_ctrl #(.IN_BITS(2), .NUM_FAULTS(6), .ERR_BITS(2), .ORA_LAT(0), .EARLY_EXIT(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.i_start   = (sel == 2'd0) ? start   : 1'b0;
    assign if_a.i_abort   = (sel == 2'd0) ? abort   : 1'b0;
    assign if_a.i_tpg_end = (sel == 2'd0) ? tpg_end : 1'b0;
    assign if_a.i_ora_res = (sel == 2'd0) ? ora_res : 1'b0;
    assign if_b.i_start   = (sel == 2'd1) ? start   : 1'b0;
    assign if_b.i_abort   = (sel == 2'd1) ? abort   : 1'b0;
    assign if_b.i_tpg_end = (sel == 2'd1) ? tpg_end : 1'b0;
    assign if_b.i_ora_res = (sel == 2'd1) ? ora_res : 1'b0;
    assign if_c.i_start   = (sel == 2'd2) ? start   : 1'b0;
    assign if_c.i_abort   = (sel == 2'd2) ? abort   : 1'b0;
    assign if_c.i_tpg_end = (sel == 2'd2) ? tpg_end : 1'b0;
    assign if_c.i_ora_res = (sel == 2'd2) ? ora_res : 1'b0;

    assign obs_a = {if_a.o_tpg_clr, if_a.o_tpg_en, if_a.o_ora_clr, if_a.o_fil_inc, if_a.o_fil_clr,
                    if_a.o_busy, if_a.o_done, if_a.o_golden_fail, 8'(if_a.o_fault_idx),
                    16'(if_a.o_det_count), 16'(if_a.o_undet_count)};
    assign obs_b = {if_b.o_tpg_clr, if_b.o_tpg_en, if_b.o_ora_clr, if_b.o_fil_inc, if_b.o_fil_clr,
                    if_b.o_busy, if_b.o_done, if_b.o_golden_fail, 8'(if_b.o_fault_idx),
                    16'(if_b.o_det_count), 16'(if_b.o_undet_count)};
    assign obs_c = {if_c.o_tpg_clr, if_c.o_tpg_en, if_c.o_ora_clr, if_c.o_fil_inc, if_c.o_fil_clr,
                    if_c.o_busy, if_c.o_done, if_c.o_golden_fail, 8'(if_c.o_fault_idx),
                    16'(if_c.o_det_count), 16'(if_c.o_undet_count)};

    always_comb begin
        case (sel)
            2'd0:    obs = obs_a;
            2'd1:    obs = obs_b;
            default: obs = obs_c;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Plays TPG and ORA for one campaign; returns right after a falling edge.
    task automatic run_campaign(input int lat, input bit ee, input int abort_fault, input int rst_fault);
        int  fault, run_j, gap, mr, md;
        bit  in_gap, early, first;
        fault = -1; run_j = 0; gap = 0; in_gap = 0; early = 0; first = 1;
        res_fil_inc = 0; res_end_fil_clr = 0; res_ended = 0;
        for (int i = 0; i < 8; i++) res_gap[i] = -1;
        start = 1'b1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; tpg_end = 1'b0; ora_res = 1'b0;
            mr = (fault >= 0 && fault < 8) ? mis_run[fault]   : -1;
            md = (fault >= 0 && fault < 8) ? mis_drain[fault] : -1;
            if (first) begin
                check("fil_clr_on_start", int'(obs.fil_clr), 1);
                first = 0;
            end
            if (obs.fil_inc) res_fil_inc++;
            if (!obs.busy) begin
                if (in_gap && fault >= 0 && fault < 8) res_gap[fault] = gap;
                res_end_fil_clr = int'(obs.fil_clr);
                res_ended = 1;
                break;
            end
            if (obs.tpg_clr) begin
                if (in_gap && fault >= 0 && fault < 8) res_gap[fault] = gap;
                fault++; run_j = 0; in_gap = 0; early = 0;
                check($sformatf("clr_idx_f%0d", fault), int'(obs.idx), fault);
                check($sformatf("ora_clr_f%0d", fault), int'(obs.ora_clr), 1);
            end else if (obs.tpg_en) begin
                run_j++;
                tpg_end = (run_j == PAT);
                ora_res = (mr == run_j);
                if (fault == 1 && run_j == 1) start = 1'b1;
                if (fault == abort_fault && run_j == 2) begin
                    abort = 1'b1;
                    start = 1'b1;
                end
                if (tpg_end || (ee && ora_res)) begin
                    in_gap = 1; gap = 0; early = ee && ora_res;
                end
            end else if (in_gap) begin
                gap++;
                ora_res = !early && (gap <= lat) && (md == gap);
                if (fault == rst_fault && gap == 1) begin
                    #2 rst = 1'b0;
                    #1 check("outs_async_reset", int'(|obs), 0);
                    res_ended = 1;
                    break;
                end
            end
        end
        check("campaign_ended", res_ended, 1);
    endtask

    task automatic check_final(input string tag, input int done, input int golden, input int idx,
                               input int det, input int undet, input int fil_inc, input int nf);
        check({tag, "_done"},    int'(obs.done), done);
        check({tag, "_busy"},    int'(obs.busy), 0);
        check({tag, "_golden"},  int'(obs.golden_fail), golden);
        check({tag, "_idx"},     int'(obs.idx), idx);
        check({tag, "_det"},     int'(obs.det), det);
        check({tag, "_undet"},   int'(obs.undet), undet);
        check({tag, "_fil_inc"}, res_fil_inc, fil_inc);
        for (int i = 0; i < nf; i++) begin
            check($sformatf("%s_gap_f%0d", tag, i), res_gap[i], exp_gap[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        sel = 2'd0; start = 1'b0; abort = 1'b0; tpg_end = 1'b0; ora_res = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs_a", int'(|obs_a), 0);
        check("reset_outs_b", int'(|obs_b), 0);
        check("reset_outs_c", int'(|obs_c), 0);
        rst = 1'b1;
        @(negedge clk);

        // Clean golden run, faults 1..3 each mismatch (fault 2 on its last pattern).
        sel = 2'd0;
        mis_run   = '{0, 2, 4, 1, 0, 0, 0, 0};
        mis_drain = '{default: 0};
        exp_gap   = '{3, 1, 1, 1, 0, 0, 0, 0};
        run_campaign(2, 1'b1, -1, -1);
        check_final("ee_all_det", 1, 0, 3, 3, 0, 3, 4);

        // FIN holds its results while the TPG/ORA lines wiggle.
        repeat (4) begin
            @(negedge clk);
            tpg_end = 1'b1; ora_res = 1'b1;
        end
        @(negedge clk);
        tpg_end = 1'b0; ora_res = 1'b0;
        check("fin_done_held", int'(obs.done), 1);
        check("fin_det_frozen", int'(obs.det), 3);
        check("fin_idx_frozen", int'(obs.idx), 3);
        check("fin_tpg_en", int'(obs.tpg_en), 0);

        // Golden run mismatches.
        mis_run = '{3, 0, 0, 0, 0, 0, 0, 0};
        exp_gap = '{1, 0, 0, 0, 0, 0, 0, 0};
        run_campaign(2, 1'b1, -1, -1);
        check_final("golden_fail", 1, 1, 0, 0, 0, 0, 1);

        // Abort (together with start) during RUN of fault 2.
        mis_run = '{0, 2, 4, 1, 0, 0, 0, 0};
        run_campaign(2, 1'b1, 2, -1);
        check("abort_fil_clr", res_end_fil_clr, 1);
        check("abort_busy", int'(obs.busy), 0);
        check("abort_done", int'(obs.done), 0);
        check("abort_det_kept", int'(obs.det), 1);
        check("abort_undet_kept", int'(obs.undet), 0);
        check("abort_fil_inc", res_fil_inc, 2);
        @(negedge clk);
        check("abort_fil_clr_pulse", int'(obs.fil_clr), 0);
        check("abort_stays_idle", int'(obs.busy), 0);
        exp_gap = '{3, 1, 1, 1, 0, 0, 0, 0};
        run_campaign(2, 1'b1, -1, -1);
        check_final("after_abort", 1, 0, 3, 3, 0, 3, 4);

        // Reset during the first drain cycle, then a fresh campaign.
        mis_run = '{default: 0};
        run_campaign(2, 1'b1, -1, 0);
        @(negedge clk);
        check("outs_held_in_reset", int'(|obs), 0);
        rst = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (obs.tpg_clr || obs.fil_inc || obs.busy) quiet++;
        end
        check("no_strobes_after_reset", quiet, 0);
        mis_run = '{0, 2, 4, 1, 0, 0, 0, 0};
        exp_gap = '{3, 1, 1, 1, 0, 0, 0, 0};
        run_campaign(2, 1'b1, -1, -1);
        check_final("after_reset", 1, 0, 3, 3, 0, 3, 4);

        // No early exit: fault 1 mismatch on last pattern, fault 2 only in drain cycle 2.
        sel = 2'd1;
        mis_run   = '{0, 4, 0, 0, 0, 0, 0, 0};
        mis_drain = '{0, 0, 2, 0, 0, 0, 0, 0};
        exp_gap   = '{3, 3, 3, 3, 0, 0, 0, 0};
        run_campaign(2, 1'b0, -1, -1);
        check_final("no_ee_drain", 1, 0, 3, 2, 1, 3, 4);

        // Two-bit counters saturate; zero ORA latency skips DRAIN.
        sel = 2'd2;
        mis_run   = '{0, 1, 2, 3, 4, 1, 0, 0};
        mis_drain = '{default: 0};
        exp_gap   = '{1, 1, 1, 1, 1, 1, 0, 0};
        run_campaign(0, 1'b1, -1, -1);
        check_final("saturate", 1, 0, 5, 3, 0, 5, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 Parameter IN_BITS, default 4, CUT input width; used to size the pattern count.
REQ-002 Parameter NUM_FAULTS, default 16, number of fault-list entries, index 0 being the fault-free golden run.
REQ-003 Parameter ERR_BITS, default 16, width of the detected/undetected counters.
REQ-004 Parameter ORA_LAT, default 2, cycles from a TPG pattern to its ORA verdict.
REQ-005 Parameter EARLY_EXIT, default 1, ends a fault's run on its first mismatch.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle campaign start request.
REQ-009 abort  in  1  campaign abort request.
REQ-010 tpg_end  in  1  TPG has issued its last pattern this cycle.
REQ-011 ora_res  in  1  ORA mismatch verdict, valid while RUN/DRAIN.
REQ-012 tpg_clr  out  1  one-cycle synchronous TPG reseed.
REQ-013 tpg_en  out  1  TPG advance enable.
REQ-014 ora_clr  out  1  one-cycle ORA clear.
REQ-015 fil_inc  out  1  one-cycle advance of the fault-injection logic.
REQ-016 fil_clr  out  1  one-cycle return of the fault-injection logic to index 0.
REQ-017 fault_idx  out  clog2(NUM_FAULTS)  current fault index.
REQ-018 det_count, undet_count  out  ERR_BITS  detected/undetected fault tallies.
REQ-019 busy, done, golden_fail  out  1  status flags.

Function
REQ-020 States SHALL be IDLE, CLR, RUN, DRAIN, EVAL, FIN; encoding is free.
REQ-021 IDLE: start SHALL go to CLR, zero both counters and fault_idx, clear done/golden_fail, and pulse fil_clr.
REQ-022 CLR (1 cycle): tpg_clr=1 and ora_clr=1 SHALL hold; clear hit flag; next state RUN.
REQ-023 RUN: tpg_en=1; ora_res=1 SHALL set hit; tpg_end SHALL go to DRAIN with a counter of ORA_LAT.
REQ-024 RUN with EARLY_EXIT=1 and ora_res=1 SHALL go directly to EVAL, with tpg_en low from the next cycle.
REQ-025 DRAIN: tpg_en=0; ora_res still ORs into hit; after exactly ORA_LAT cycles go to EVAL; ORA_LAT=0 SHALL skip DRAIN.
REQ-026 EVAL (1 cycle), fault_idx=0: hit=1 SHALL set golden_fail and go to FIN; else fil_inc=1, fault_idx+1, go to CLR.
REQ-027 EVAL, fault_idx>0: hit increments det_count else undet_count; saturating at all-ones, no wrap.
REQ-028 EVAL at fault_idx=NUM_FAULTS-1 SHALL go to FIN with no fil_inc; otherwise fil_inc=1, fault_idx+1, go to CLR.
REQ-029 FIN: done=1 held; counters and fault_idx frozen; start SHALL restart per REQ-021.
REQ-030 busy SHALL be 1 in CLR, RUN, DRAIN and EVAL, else 0.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort in any state SHALL return to IDLE next cycle: fil_clr pulse, counters retained, done=0; abort beats start when both are high.
REQ-033 tpg_end and ora_res together in RUN: the mismatch counts and the transition is to DRAIN (EARLY_EXIT=0) or EVAL (EARLY_EXIT=1).
REQ-034 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-035 rst low SHALL force IDLE, all counters, fault_idx and flags to 0, and every strobe output to 0, independent of clk.
REQ-036 Reset release mid-campaign SHALL never produce fil_inc or tpg_clr until a new start.

Structure
REQ-037 The state enum, FAULT_IDX_W and a saturating-increment function SHALL live in the shared package bist_pkg.
REQ-038 A single sub-module, lat_drain_cnt (load ORA_LAT, count down, zero flag), is natural; all else inline.

Verification
REQ-039 NUM_FAULTS=4, ORA_LAT=2, clean golden run, faults 1..3 mismatch -> done=1, det_count=3, undet_count=0, fil_inc pulses=3.
REQ-040 Golden run with ora_res=1 -> golden_fail=1, done=1, fault_idx=0, both counters 0.
REQ-041 EARLY_EXIT=0, ora_res=1 only in the 2nd DRAIN cycle of fault 2 -> fault 2 counted detected; drain spans exactly 2 cycles.
REQ-042 ERR_BITS=2, NUM_FAULTS=6, all faults detected -> det_count saturates at 3.
REQ-043 abort asserted in RUN of fault 2 -> IDLE next cycle, fil_clr=1, busy=0, done=0, counters unchanged; a later start gives a clean full campaign.
REQ-044 rst pulsed low in DRAIN, then start -> all outputs 0 during reset, and the campaign restarts from fault_idx=0.
